// File: rtl/test_stream_checker_pkg.sv
// Shared constants and types for the test-stream checker: frame layout, checksum seed, state encoding.
package test_stream_checker_pkg;

    localparam int unsigned CS_SEED_DEFAULT = 47;
    localparam logic [6:0]  CNT_STEP        = 7'd111;

    // Sync nibble {byte3, byte2, byte1, byte0} expected for each word position of a frame.
    localparam logic [3:0]  SYNC_MASK_DATA  = 4'b1010;
    localparam logic [3:0]  SYNC_MASK_LAST  = 4'b1110;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic logic [3:0] sync_mask(input logic [1:0] widx);
        return (widx == 2'd3) ? SYNC_MASK_LAST : SYNC_MASK_DATA;
    endfunction

endpackage

// File: rtl/test_stream_checker_frame_cs.sv
// Running 14-bit frame checksum over accepted bytes 0..14, folded to the 7-bit value carried in byte 15.
module test_frame_cs
    import test_stream_checker_pkg::*;
#(
    parameter int unsigned CS_SEED = CS_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        acc_en,
    input  logic        last,
    input  logic [31:0] word,
    output logic [6:0]  cs_fold
);
    localparam logic [13:0] SEED14 = 14'(CS_SEED);

    logic [13:0] cs_q;
    logic [13:0] cs_d;
    logic [13:0] sum_head;
    logic [13:0] cs_upd;

    // On the last word only bytes 12..14 belong to the sum; byte 15 is the checksum itself.
    always_comb begin
        sum_head = {6'd0, word[7:0]} + {6'd0, word[15:8]} + {6'd0, word[23:16]};
        cs_upd   = cs_q + sum_head + (last ? 14'd0 : {6'd0, word[31:24]});
        cs_fold  = cs_upd[6:0] ^ cs_upd[13:7];
        cs_d     = cs_q;
        if (init) begin
            cs_d = SEED14;
        end else if (acc_en) begin
            cs_d = last ? SEED14 : cs_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q <= SEED14;
        end else begin
            cs_q <= cs_d;
        end
    end

endmodule

// File: rtl/test_stream_checker.sv
// Checks a 16-byte framed counter stream: hunts for frame alignment, then verifies sync bits,
// byte sequence and checksum per frame, keeping frame/error statistics.
module test_stream_checker
    import test_stream_checker_pkg::*;
#(
    parameter int unsigned LOSS_THRESH = 2,
    parameter int unsigned CS_SEED     = CS_SEED_DEFAULT
) (
    input  logic        ifclk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] DI,
    input  logic        DI_valid,
    output logic        DI_ready,
    output logic        locked,
    output logic [31:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic        err
);
    localparam int unsigned      RUN_W     = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(LOSS_THRESH);

    // Handshake: a word transfers on every rising edge where DI_valid && DI_ready; DI_valid may
    // drop for any number of cycles and DI_ready, once up after reset, never drops.
    logic             ready_q, ready_d;
    logic             s1_vld_q, s1_vld_d;
    logic [31:0]      s1_word_q, s1_word_d;
    state_e           state_q, state_d;
    logic [1:0]       widx_q, widx_d;
    logic [6:0]       pred_q, pred_d;
    logic             frame_bad_q, frame_bad_d;
    logic [RUN_W-1:0] bad_run_q, bad_run_d;
    logic             res_vld_q, res_vld_d;
    logic             res_bad_q, res_bad_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             err_q, err_d;

    logic [3:0]       sync_bits;
    logic [6:0]       v0, v1, v2, v3;
    logic [6:0]       e0, e1, e2, e3;
    logic [RUN_W-1:0] run_inc;
    logic             lock_hit, frame_end, word_bad, frame_bad_now, lose_lock;
    logic             cs_init, cs_acc;
    logic [6:0]       cs_fold;

    test_frame_cs #(.CS_SEED(CS_SEED)) u_frame_cs (
        .clk     (ifclk),
        .reset   (reset),
        .init    (cs_init),
        .acc_en  (cs_acc),
        .last    (frame_end),
        .word    (s1_word_q),
        .cs_fold (cs_fold)
    );

    always_comb begin
        ready_d   = 1'b1;
        s1_vld_d  = DI_valid && ready_q;
        s1_word_d = (DI_valid && ready_q) ? DI : s1_word_q;
    end

    // Compare stage: checks the registered word against the running prediction.
    always_comb begin
        sync_bits     = {s1_word_q[31], s1_word_q[23], s1_word_q[15], s1_word_q[7]};
        v0            = s1_word_q[6:0];
        v1            = s1_word_q[14:8];
        v2            = s1_word_q[22:16];
        v3            = s1_word_q[30:24];
        e0            = pred_q;
        e1            = e0 + CNT_STEP;
        e2            = e1 + CNT_STEP;
        e3            = e2 + CNT_STEP;
        lock_hit      = (sync_bits == SYNC_MASK_LAST);
        frame_end     = (widx_q == 2'd3);
        word_bad      = (sync_bits != sync_mask(widx_q)) || (v0 != e0) || (v1 != e1) || (v2 != e2)
                        || (frame_end ? (v3 != cs_fold) : (v3 != e3));
        frame_bad_now = frame_bad_q || word_bad;
        run_inc       = bad_run_q + RUN_W'(1);
        lose_lock     = s1_vld_q && (state_q == ST_LOCKED) && frame_end && frame_bad_now
                        && (run_inc >= RUN_LIMIT);
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT:   if (s1_vld_q && lock_hit) state_d = ST_LOCKED;
            ST_LOCKED: if (lose_lock)            state_d = ST_HUNT;
            default:                             state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

    always_comb begin
        widx_d      = widx_q;
        pred_d      = pred_q;
        frame_bad_d = frame_bad_q;
        bad_run_d   = bad_run_q;
        res_vld_d   = 1'b0;
        res_bad_d   = 1'b0;
        cs_init     = 1'b0;
        cs_acc      = 1'b0;
        if (s1_vld_q) begin
            if (state_q == ST_HUNT) begin
                if (lock_hit) begin
                    widx_d      = 2'd0;
                    pred_d      = v2 + CNT_STEP;
                    frame_bad_d = 1'b0;
                    cs_init     = 1'b1;
                end
            end else begin
                cs_acc = 1'b1;
                if (!frame_end) begin
                    widx_d      = widx_q + 2'd1;
                    pred_d      = e3 + CNT_STEP;
                    frame_bad_d = frame_bad_now;
                end else begin
                    // Next frame is predicted from the received byte 14, so a bad frame resyncs.
                    widx_d      = 2'd0;
                    pred_d      = v2 + CNT_STEP;
                    frame_bad_d = 1'b0;
                    res_vld_d   = 1'b1;
                    res_bad_d   = frame_bad_now;
                    bad_run_d   = (!frame_bad_now || lose_lock) ? '0 : run_inc;
                end
            end
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_d       = err_q;
        if (clear) begin
            frame_cnt_d = 32'd0;
            err_cnt_d   = 16'd0;
            err_d       = 1'b0;
        end else if (res_vld_q) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            if (res_bad_q) begin
                err_d = 1'b1;
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            ready_q     <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_word_q   <= 32'd0;
            widx_q      <= 2'd0;
            pred_q      <= 7'd0;
            frame_bad_q <= 1'b0;
            bad_run_q   <= '0;
            res_vld_q   <= 1'b0;
            res_bad_q   <= 1'b0;
            frame_cnt_q <= 32'd0;
            err_cnt_q   <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            s1_vld_q    <= s1_vld_d;
            s1_word_q   <= s1_word_d;
            widx_q      <= widx_d;
            pred_q      <= pred_d;
            frame_bad_q <= frame_bad_d;
            bad_run_q   <= bad_run_d;
            res_vld_q   <= res_vld_d;
            res_bad_q   <= res_bad_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_q       <= err_d;
        end
    end

    assign DI_ready  = ready_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_test_stream_checker.sv
// Bench for test_stream_checker: frame generator, frame-level reference model and per-scenario checks.
module tb_test_stream_checker;

    localparam int STEP    = 111;
    localparam int SEED_TB = 47;
    localparam int LOSS_TB = 2;

    logic        ifclk = 1'b0;
    logic        reset;
    logic        clear;
    logic [31:0] DI;
    logic        DI_valid;
    logic        DI_ready;
    logic        locked;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;
    logic        err;

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard: verdict (1 = bad) of every frame completed since the last reset or clear.
    logic [0:0] exp_q[$];

    // Reference model state
    bit m_locked;
    int m_widx;
    int m_pred;
    int m_run;
    int m_bytes [16];

    // Generator state
    int          g_val;
    logic [31:0] frm [4];

    test_stream_checker #(.LOSS_THRESH(LOSS_TB), .CS_SEED(SEED_TB)) dut (
        .ifclk     (ifclk),
        .reset     (reset),
        .clear     (clear),
        .DI        (DI),
        .DI_valid  (DI_valid),
        .DI_ready  (DI_ready),
        .locked    (locked),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .err       (err)
    );

    always #5 ifclk = ~ifclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, run did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int sync_of(input int k);
        return ((k % 2) == 1 || k == 14) ? 1 : 0;
    endfunction

    function automatic int fold_cs(input int sum);
        int cs;
        cs = sum % 16384;
        return (cs % 128) ^ (cs / 128);
    endfunction

    function automatic int exp_frames();
        return exp_q.size();
    endfunction

    function automatic int exp_errs();
        int n;
        n = 0;
        foreach (exp_q[i]) if (exp_q[i] == 1'b1) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_widx   = 0;
        m_pred   = 0;
        m_run    = 0;
        exp_q.delete();
    endtask

    // Frame-level model: collects 16 bytes and judges the whole frame against the stream rules.
    task automatic model_accept(input logic [31:0] w);
        bit bad;
        int sum;
        if (!m_locked) begin
            if ({w[31], w[23], w[15], w[7]} == 4'b1110) begin
                m_locked = 1'b1;
                m_widx   = 0;
                m_pred   = (int'(w[22:16]) + STEP) % 128;
            end
        end else begin
            for (int i = 0; i < 4; i++) m_bytes[4*m_widx+i] = int'(w[8*i +: 8]);
            if (m_widx < 3) begin
                m_widx++;
            end else begin
                bad = 1'b0;
                sum = SEED_TB;
                for (int k = 0; k < 16; k++)
                    if (((m_bytes[k] >> 7) & 1) != sync_of(k)) bad = 1'b1;
                for (int k = 0; k < 15; k++) begin
                    if ((m_bytes[k] & 127) != (m_pred + STEP * k) % 128) bad = 1'b1;
                    sum += m_bytes[k];
                end
                if ((m_bytes[15] & 127) != fold_cs(sum)) bad = 1'b1;
                exp_q.push_back(bad);
                m_run = bad ? m_run + 1 : 0;
                if (m_run >= LOSS_TB) begin
                    m_locked = 1'b0;
                    m_run    = 0;
                end
                m_pred = ((m_bytes[14] & 127) + STEP) % 128;
                m_widx = 0;
            end
        end
    endtask

    task automatic make_frame();
        int b [16];
        int sum;
        sum = SEED_TB;
        for (int k = 0; k < 15; k++) begin
            b[k] = (sync_of(k) << 7) | ((g_val + STEP * k) % 128);
            sum += b[k];
        end
        b[15] = 128 | fold_cs(sum);
        g_val = ((b[14] & 127) + STEP) % 128;
        for (int w = 0; w < 4; w++)
            frm[w] = {8'(b[4*w+3]), 8'(b[4*w+2]), 8'(b[4*w+1]), 8'(b[4*w])};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ifclk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        int waited;
        waited   = 0;
        DI       = w;
        DI_valid = 1'b1;
        while (DI_ready !== 1'b1 && waited < 50) begin
            @(posedge ifclk);
            #1;
            waited++;
        end
        if (DI_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_word_ready: DI_ready=%b required 1 within 50 cycles", DI_ready);
        end else begin
            @(posedge ifclk);
            #1;
            model_accept(w);
        end
        DI_valid = 1'b0;
        DI       = $urandom;
        idle(gap);
    endtask

    task automatic send_frame(input int gap_max);
        for (int w = 0; w < 4; w++) send_word(frm[w], $urandom_range(gap_max, 0));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        tests_run++;
        if (DI_ready !== 1'b0 || locked !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: ready=%b locked=%b err=%b required 0 0 0", DI_ready, locked, err);
        end
        tests_run++;
        if (frame_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_counts: frame_cnt=%0d err_cnt=%0d required 0 0", frame_cnt, err_cnt);
        end
        reset = 1'b0;
        model_reset();
        tests_run++;
        if (DI_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_after: DI_ready=%b required 0", DI_ready);
        end
        idle(1);
        tests_run++;
        if (DI_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_up: DI_ready=%b required 1", DI_ready);
        end
    endtask

    task automatic test_lock();
        send_word(32'hCD5EEF00, 0);
        send_word(32'h891AAB3C, 0);
        send_word(32'hC556E778, 0);
        idle(2);
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_before: locked=%b required 0", locked);
        end
        send_word(32'hB992A334, 0);
        idle(2);
        tests_run++;
        if (locked !== m_locked || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_hit: locked=%b required 1", locked);
        end
        tests_run++;
        if (frame_cnt !== 32'(exp_frames()) || err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL lock_counts: frame_cnt=%0d err_cnt=%0d required %0d 0", frame_cnt, err_cnt, exp_frames());
        end
        g_val = 1;
    endtask

    task automatic test_good_frame();
        make_frame();
        send_frame(0);
        idle(1);
        tests_run++;
        if (frame_cnt !== 32'(exp_frames() - 1)) begin
            tests_failed++;
            $display("FAIL good_latency_early: frame_cnt=%0d required %0d", frame_cnt, exp_frames() - 1);
        end
        idle(1);
        tests_run++;
        if (frame_cnt !== 32'(exp_frames()) || frame_cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL good_frame_cnt: frame_cnt=%0d required 1", frame_cnt);
        end
        tests_run++;
        if (err_cnt !== 16'd0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL good_err: err_cnt=%0d err=%b required 0 0", err_cnt, err);
        end
    endtask

    task automatic test_bad_checksum();
        make_frame();
        frm[3][31:24] = 8'hB8;
        send_frame(0);
        idle(2);
        tests_run++;
        if (err_cnt !== 16'(exp_errs()) || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL badcs_err: err_cnt=%0d err=%b required %0d 1", err_cnt, err, exp_errs());
        end
        make_frame();
        send_frame(0);
        idle(2);
        tests_run++;
        if (err_cnt !== 16'(exp_errs()) || frame_cnt !== 32'(exp_frames())) begin
            tests_failed++;
            $display("FAIL badcs_next: err_cnt=%0d frame_cnt=%0d required %0d %0d", err_cnt, frame_cnt, exp_errs(), exp_frames());
        end
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL badcs_locked: locked=%b required 1", locked);
        end
    endtask

    task automatic test_loss();
        make_frame();
        frm[0][15] = 1'b0;
        send_frame(0);
        idle(2);
        tests_run++;
        if (locked !== m_locked) begin
            tests_failed++;
            $display("FAIL loss_first: locked=%b required %b", locked, m_locked);
        end
        make_frame();
        frm[0][15] = 1'b0;
        send_frame(0);
        idle(2);
        tests_run++;
        if (locked !== 1'b0 || locked !== m_locked) begin
            tests_failed++;
            $display("FAIL loss_second: locked=%b required 0", locked);
        end
        tests_run++;
        if (frame_cnt !== 32'(exp_frames()) || err_cnt !== 16'(exp_errs())) begin
            tests_failed++;
            $display("FAIL loss_counts: frame_cnt=%0d err_cnt=%0d required %0d %0d", frame_cnt, err_cnt, exp_frames(), exp_errs());
        end
        make_frame();
        send_frame(0);
        idle(2);
        tests_run++;
        if (locked !== 1'b1 || frame_cnt !== 32'(exp_frames())) begin
            tests_failed++;
            $display("FAIL loss_relock: locked=%b frame_cnt=%0d required 1 %0d", locked, frame_cnt, exp_frames());
        end
        make_frame();
        send_frame(0);
        idle(2);
        tests_run++;
        if (frame_cnt !== 32'(exp_frames()) || err_cnt !== 16'(exp_errs())) begin
            tests_failed++;
            $display("FAIL loss_after: frame_cnt=%0d err_cnt=%0d required %0d %0d", frame_cnt, err_cnt, exp_frames(), exp_errs());
        end
    endtask

    task automatic test_gaps();
        do_clear();
        for (int i = 0; i < 100; i++) begin
            make_frame();
            send_frame(5);
        end
        idle(3);
        tests_run++;
        if (frame_cnt !== 32'(exp_frames()) || frame_cnt !== 32'd100) begin
            tests_failed++;
            $display("FAIL gaps_frame_cnt: frame_cnt=%0d required 100", frame_cnt);
        end
        tests_run++;
        if (err_cnt !== 16'd0 || err !== 1'b0 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL gaps_status: err_cnt=%0d err=%b locked=%b required 0 0 1", err_cnt, err, locked);
        end
        do_clear();
        idle(1);
        tests_run++;
        if (frame_cnt !== 32'd0 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL gaps_clear: frame_cnt=%0d locked=%b required 0 1", frame_cnt, locked);
        end
    endtask

    task automatic test_clear_collision();
        make_frame();
        frm[3][24] = ~frm[3][24];
        send_frame(0);
        idle(1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        exp_q.delete();
        idle(2);
        tests_run++;
        if (frame_cnt !== 32'd0 || err_cnt !== 16'd0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_collision: frame_cnt=%0d err_cnt=%0d err=%b required 0 0 0", frame_cnt, err_cnt, err);
        end
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_collision_locked: locked=%b required 1", locked);
        end
    endtask

    task automatic test_random();
        int k;
        int b;
        for (int i = 0; i < 40; i++) begin
            make_frame();
            if ($urandom_range(2, 0) == 0) begin
                k = $urandom_range(15, 0);
                b = $urandom_range(7, 0);
                frm[k/4][8*(k%4)+b] = ~frm[k/4][8*(k%4)+b];
            end
            send_frame(2);
        end
        idle(3);
        tests_run++;
        if (frame_cnt !== 32'(exp_frames()) || err_cnt !== 16'(exp_errs())) begin
            tests_failed++;
            $display("FAIL random_counts: frame_cnt=%0d err_cnt=%0d required %0d %0d", frame_cnt, err_cnt, exp_frames(), exp_errs());
        end
        tests_run++;
        if (err !== (exp_errs() > 0) || locked !== m_locked) begin
            tests_failed++;
            $display("FAIL random_flags: err=%b locked=%b required %b %b", err, locked, exp_errs() > 0, m_locked);
        end
    endtask

    task automatic test_reset_mid_frame();
        make_frame();
        send_frame(0);
        make_frame();
        send_frame(0);
        make_frame();
        send_word(frm[0], 0);
        send_word(frm[1], 0);
        reset = 1'b1;
        idle(1);
        tests_run++;
        if (DI_ready !== 1'b0 || locked !== 1'b0 || err !== 1'b0 || frame_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: ready=%b locked=%b err=%b frame_cnt=%0d err_cnt=%0d required all 0",
                     DI_ready, locked, err, frame_cnt, err_cnt);
        end
        reset = 1'b0;
        model_reset();
        idle(6);
        tests_run++;
        if (frame_cnt !== 32'd0 || err_cnt !== 16'd0 || locked !== 1'b0 || DI_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_quiet: frame_cnt=%0d err_cnt=%0d locked=%b ready=%b required 0 0 0 1",
                     frame_cnt, err_cnt, locked, DI_ready);
        end
        make_frame();
        send_frame(1);
        make_frame();
        send_frame(1);
        idle(3);
        tests_run++;
        if (frame_cnt !== 32'(exp_frames()) || frame_cnt !== 32'd1 || err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL midreset_recover: frame_cnt=%0d err_cnt=%0d required 1 0", frame_cnt, err_cnt);
        end
    endtask

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        DI       = 32'd0;
        DI_valid = 1'b0;
        g_val    = 0;
        model_reset();
        test_reset();
        test_lock();
        test_good_frame();
        test_bad_checksum();
        test_loss();
        test_gaps();
        test_clear_collision();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/test_stream_checker.md
TEST_STREAM_CHECKER -- requirements
Module: test_stream_checker

Interface
REQ-001 Parameter LOSS_THRESH, default 2: consecutive bad frames that force return to HUNT.
REQ-002 Parameter CS_SEED, default 47: checksum accumulator start value per frame.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 ifclk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous; zeroes counters and sticky flag, keeps lock state.
REQ-007 DI  input  32  FIFO read data; byte 0 in [7:0], little-endian byte order.
REQ-008 DI_valid  input  1  DI holds a word.
REQ-009 DI_ready  output  1  registered; word accepted on any cycle with DI_valid && DI_ready.
REQ-010 locked  output  1  frame alignment held (state LOCKED).
REQ-011 frame_cnt  output  32  frames checked while locked, wraps at 2^32.
REQ-012 err_cnt  output  16  bad frames, saturates at 16'hFFFF.
REQ-013 err  output  1  sticky; set on any bad frame.

Function
REQ-014 Stream format: 16-byte frame = 4 words; byte = {sync, val[6:0]}; sync per byte 0..15 = 0,1,0,1,0,1,0,1,0,1,0,1,0,1,1,1.
REQ-015 Data bytes 0..14: val(k+1) = val(k)+111 mod 128; byte 0 of next frame = byte 14 of previous frame +111 mod 128.
REQ-016 Checksum: cs (14-bit) = CS_SEED + sum of full 8-bit bytes 0..14; byte 15 val = cs[6:0] ^ cs[13:7].
REQ-017 DI_ready = 0 during reset and the cycle after it, then 1 permanently; the block never back-pressures.
REQ-018 States HUNT, LOCKED; reset enters HUNT.
REQ-019 HUNT: an accepted word with sync bits {DI[31],DI[23],DI[15],DI[7]} = 4'b1110 -> LOCKED; next accepted word is frame word 0; expected val = DI[22:16]+111 mod 128.
REQ-020 LOCKED: per word, check the 4 sync bits, 4 (word 3: 3) val predictions, and accumulate cs; at word 3, also compare the checksum byte.
REQ-021 A frame is bad if any check in it fails; it counts once in err_cnt regardless of how many bytes fail.
REQ-022 After a bad frame, the prediction resynchronises to the received byte 14.
REQ-023 frame_cnt increments by 1 per completed frame in LOCKED, good or bad.
REQ-024 LOSS_THRESH consecutive bad frames -> HUNT; the bad-run counter clears on any good frame.
REQ-025 Latency: frame_cnt, err_cnt, err update 2 cycles after word 3 is accepted (register stage + compare stage).
REQ-026 DI_valid gaps of any length between words do not affect checking; words are counted only on acceptance.
REQ-027 clear in the same cycle as a frame result: clear wins, and that result is dropped.
REQ-028 err_cnt saturation: err_cnt stays 16'hFFFF; err stays 1.

Reset
REQ-029 Reset values: DI_ready=0, locked=0, frame_cnt=0, err_cnt=0, err=0, word index=0, cs=CS_SEED, bad-run=0, pipeline valids=0.
REQ-030 Reset mid-frame discards the partial frame; no count update follows.

Structure
REQ-031 Shared package holds CS_SEED default, CNT_STEP=111, SYNC_MASK per word (4'b1010 words 0-2, 4'b1110 word 3), and the state enum.
REQ-032 One sub-module, test_frame_cs: accumulates cs over accepted bytes and outputs the folded 7-bit checksum.

Verification
REQ-033 Reset, then words 0xCD5EEF00, 0x891AAB3C, 0xC556E778, 0xB992A334 -> HUNT locks on 0xB992A334; locked=1, no count change.
REQ-034 Locked, next frame starting byte 0x01 and correctly formed -> frame_cnt=1, err_cnt=0, err=0, 2 cycles after its word 3.
REQ-035 Locked, frame with byte 15 = 0xB8 instead of correct checksum -> err_cnt=1, err=1; next good frame -> err_cnt stays 1, locked stays 1.
REQ-036 LOSS_THRESH=2, two consecutive frames with byte 1 sync bit cleared -> locked=0 after the second frame; the next 4'b1110 word relocks.
REQ-037 Random DI_valid gaps (0-5 cycles) on 100 good frames -> frame_cnt=100, err_cnt=0; clear pulse -> frame_cnt=0, locked unchanged.
REQ-038 Reset asserted after word 1 of a frame -> all outputs at reset values next cycle; no spurious count.
